mac_data_loader: RTL and testbench

- Input-side sequencer between the boundary-scanned pin interface and the N×N systolic MAC array.
- Collects the byte stream (data_v/data_mode/data_rst_addr/data) into a double-buffered weight matrix and activation vectors.
- Hands weights and activations to the array with a commit pulse and a valid/ready handshake.
- Exposes its registers on the JTAG user-register read port.

---
 rtl/mac_data_loader.sv | 160 ++++++++++++++++
 tb/tb_mac_data_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_data_loader.sv
// rtl/mac_data_loader.sv - byte-stream loader feeding weights and activations to the systolic MAC array
// Double-buffers the weight matrix and hands off activation vectors through a 1-entry output register.
module mac_data_loader #(
   parameter int W = 8,
   parameter int N = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               data_v_i,
   input  logic               data_mode_i,
   input  logic               data_rst_addr_i,
   input  logic [W-1:0]       data_i,
   input  logic               act_rdy_i,
   output logic [N*N*W-1:0]   weight_o,
   output logic               weight_v_o,
   output logic [N*W-1:0]     act_o,
   output logic               act_v_o,
   output logic               ovf_o,
   input  logic [3:0]         ureg_addr_i,
   output logic [7:0]         ureg_data_o
);

   localparam int NW   = N * N;
   localparam int WI_W = (NW > 1) ? $clog2(NW) : 1;
   localparam int AI_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      W_FILL = 2'd1,
      A_FILL = 2'd2
   } state_t;

   state_t             r_state;
   logic [WI_W-1:0]    r_widx;
   logic [AI_W-1:0]    r_aidx;
   logic [NW*W-1:0]    r_shadow;
   logic [NW*W-1:0]    r_weight;
   logic               r_weight_v;
   logic [N*W-1:0]     r_abuf;
   logic [N*W-1:0]     r_act;
   logic               r_act_v;
   logic               r_ovf;

   logic               w_wbeat;
   logic               w_abeat;
   logic [WI_W-1:0]    w_widx_eff;
   logic [AI_W-1:0]    w_aidx_eff;
   logic               w_w_last;
   logic               w_a_last;
   logic               w_xfer;
   logic               w_a_drop;
   logic [NW*W-1:0]    w_shadow_nxt;
   logic [N*W-1:0]     w_abuf_nxt;
   logic [1:0]         w_widx2;
   logic [7:0]         w_status;
   logic [7:0]         w_ureg;

   // A beat of the other kind restarts filling at index 0, so the effective index is 0 outside the matching state.
   assign w_wbeat    = data_v_i & ~data_rst_addr_i & ~data_mode_i;
   assign w_abeat    = data_v_i & ~data_rst_addr_i & data_mode_i;
   assign w_widx_eff = (r_state == W_FILL) ? r_widx : '0;
   assign w_aidx_eff = (r_state == A_FILL) ? r_aidx : '0;
   assign w_w_last   = (w_widx_eff == WI_W'(NW - 1));
   assign w_a_last   = (w_aidx_eff == AI_W'(N - 1));
   assign w_xfer     = r_act_v & act_rdy_i;
   assign w_a_drop   = r_act_v & ~act_rdy_i;

   always_comb begin
      w_shadow_nxt = r_shadow;
      for (int k = 0; k < NW; k++) begin
         if (w_widx_eff == WI_W'(k)) w_shadow_nxt[k*W +: W] = data_i;
      end
   end

   always_comb begin
      w_abuf_nxt = r_abuf;
      for (int j = 0; j < N; j++) begin
         if (w_aidx_eff == AI_W'(j)) w_abuf_nxt[j*W +: W] = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_widx     <= '0;
         r_aidx     <= '0;
         r_shadow   <= '0;
         r_weight   <= '0;
         r_weight_v <= 1'b0;
         r_abuf     <= '0;
         r_act      <= '0;
         r_act_v    <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (ena) begin
         r_weight_v <= 1'b0;
         if (data_rst_addr_i) begin
            r_widx  <= '0;
            r_aidx  <= '0;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
         end else begin
            if (w_xfer) r_act_v <= 1'b0;
            if (w_wbeat) begin
               r_shadow <= w_shadow_nxt;
               r_aidx   <= '0;
               if (w_w_last) begin
                  r_weight   <= w_shadow_nxt;
                  r_weight_v <= 1'b1;
                  r_widx     <= '0;
                  r_state    <= IDLE;
               end else begin
                  r_widx  <= w_widx_eff + WI_W'(1);
                  r_state <= W_FILL;
               end
            end else if (w_abeat) begin
               r_abuf <= w_abuf_nxt;
               r_widx <= '0;
               if (w_a_last) begin
                  r_aidx  <= '0;
                  r_state <= IDLE;
                  // A held, unaccepted vector wins; the newcomer is lost and flagged.
                  if (w_a_drop) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_act   <= w_abuf_nxt;
                     r_act_v <= 1'b1;
                  end
               end else begin
                  r_aidx  <= w_aidx_eff + AI_W'(1);
                  r_state <= A_FILL;
               end
            end
         end
      end
   end

   assign w_widx2  = 2'(r_widx);
   assign w_status = {r_ovf, r_act_v, r_state[1:0], w_widx2, r_aidx[0], 1'b0};

   always_comb begin
      w_ureg = 8'h00;
      for (int k = 0; k < NW; k++) begin
         if (ureg_addr_i == 4'(k)) w_ureg = 8'(r_weight[k*W +: W]);
      end
      for (int j = 0; j < N; j++) begin
         if (ureg_addr_i == 4'(NW + j)) w_ureg = 8'(r_act[j*W +: W]);
      end
      if (ureg_addr_i == 4'hE) w_ureg = w_status;
      if (ureg_addr_i == 4'hF) w_ureg = 8'hA5;
   end

   assign weight_o    = r_weight;
   assign weight_v_o  = r_weight_v & ena;
   assign act_o       = r_act;
   assign act_v_o     = r_act_v;
   assign ovf_o       = r_ovf;
   assign ureg_data_o = w_ureg;

endmodule

// File: tb/tb_mac_data_loader.sv
// tb/tb_mac_data_loader.sv - directed and randomized check of mac_data_loader against a byte-list model
module tb_mac_data_loader;

   localparam int W = 8;
   localparam int N = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ena;
   logic          data_v_i;
   logic          data_mode_i;
   logic          data_rst_addr_i;
   logic [W-1:0]  data_i;
   logic          act_rdy_i;
   logic [N*N*W-1:0] weight_o;
   logic          weight_v_o;
   logic [N*W-1:0] act_o;
   logic          act_v_o;
   logic          ovf_o;
   logic [3:0]    ureg_addr_i;
   logic [7:0]    ureg_data_o;

   int total = 0;
   int bad = 0;

   logic [31:0] m_weight;
   logic [15:0] m_act;
   logic        m_wv, m_av, m_ovf, m_kind;
   logic [7:0]  q[$];

   always #5 clk = ~clk;

   mac_data_loader #(.W(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .data_v_i(data_v_i), .data_mode_i(data_mode_i), .data_rst_addr_i(data_rst_addr_i),
      .data_i(data_i), .act_rdy_i(act_rdy_i),
      .weight_o(weight_o), .weight_v_o(weight_v_o),
      .act_o(act_o), .act_v_o(act_v_o), .ovf_o(ovf_o),
      .ureg_addr_i(ureg_addr_i), .ureg_data_o(ureg_data_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic void model_reset();
      m_weight = '0; m_act = '0; m_wv = 1'b0; m_av = 1'b0; m_ovf = 1'b0; m_kind = 1'b0;
      q.delete();
   endfunction

   // Model: the bytes collected so far form a list of one kind; a full list is a matrix or a vector.
   function automatic void model_cycle(input logic v, m, ra, input logic [7:0] d, input logic rdy, en);
      logic newv, oldav;
      if (!en) return;
      m_wv = 1'b0;
      if (ra) begin
         q.delete();
         m_ovf = 1'b0;
         return;
      end
      newv = 1'b0;
      oldav = m_av;
      if (v) begin
         if (q.size() == 0 || m_kind != m) begin
            q.delete();
            m_kind = m;
         end
         q.push_back(d);
         if (!m && q.size() == N*N) begin
            for (int k = 0; k < N*N; k++) m_weight[k*8 +: 8] = q[k];
            m_wv = 1'b1;
            q.delete();
         end else if (m && q.size() == N) begin
            if (oldav && !rdy) m_ovf = 1'b1;
            else begin
               for (int j = 0; j < N; j++) m_act[j*8 +: 8] = q[j];
               newv = 1'b1;
            end
            q.delete();
         end
      end
      if (newv) m_av = 1'b1;
      else if (oldav && rdy) m_av = 1'b0;
   endfunction

   function automatic logic [7:0] exp_ureg(input logic [3:0] a);
      logic [1:0] st;
      int wi, ai;
      logic [7:0] r;
      st = (q.size() == 0) ? 2'd0 : (m_kind ? 2'd2 : 2'd1);
      wi = m_kind ? 0 : q.size();
      ai = m_kind ? q.size() : 0;
      if (a == 4'hF) r = 8'hA5;
      else if (a == 4'hE) r = {m_ovf, m_av, st, wi[1:0], ai[0], 1'b0};
      else if (a < 4) r = m_weight[a*8 +: 8];
      else if (a < 6) r = m_act[(a-4)*8 +: 8];
      else r = 8'h00;
      return r;
   endfunction

   task automatic step(input logic v, m, ra, input logic [7:0] d, input logic rdy, en);
      data_v_i = v; data_mode_i = m; data_rst_addr_i = ra; data_i = d; act_rdy_i = rdy; ena = en;
      model_cycle(v, m, ra, d, rdy, en);
      @(posedge clk); #1;
      check("weight_o", weight_o, m_weight);
      check("weight_v_o", weight_v_o, m_wv & en);
      check("act_o", act_o, m_act);
      check("act_v_o", act_v_o, m_av);
      check("ovf_o", ovf_o, m_ovf);
      ureg_addr_i = 4'($urandom_range(0, 15));
      #1;
      check("ureg_rand", ureg_data_o, exp_ureg(ureg_addr_i));
   endtask

   task automatic wb(input logic [7:0] d, input logic rdy); step(1'b1, 1'b0, 1'b0, d, rdy, 1'b1); endtask
   task automatic ab(input logic [7:0] d, input logic rdy); step(1'b1, 1'b1, 1'b0, d, rdy, 1'b1); endtask
   task automatic idle(input logic rdy); step(1'b0, 1'b0, 1'b0, 8'h00, rdy, 1'b1); endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_weight", weight_o, 0);
      check("arst_wv", weight_v_o, 0);
      check("arst_act", act_o, 0);
      check("arst_av", act_v_o, 0);
      check("arst_ovf", ovf_o, 0);
      #2 rst_n = 1'b1;
   endtask

   task automatic ureg_chk(input logic [3:0] a, input logic [7:0] exp);
      ureg_addr_i = a;
      #1;
      check("ureg_dir", ureg_data_o, exp);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; data_v_i = 1'b0; data_mode_i = 1'b0; data_rst_addr_i = 1'b0;
      data_i = '0; act_rdy_i = 1'b0; ureg_addr_i = 4'h0;
      model_reset();
      #12;
      check("rst_weight", weight_o, 0);
      check("rst_wv", weight_v_o, 0);
      check("rst_act", act_o, 0);
      check("rst_av", act_v_o, 0);
      check("rst_ovf", ovf_o, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      wb(8'h11, 1'b0); wb(8'h22, 1'b0); wb(8'h33, 1'b0);
      check("pre_commit_weight", weight_o, 32'h0);
      wb(8'h44, 1'b0);
      check("commit_weight", weight_o, 32'h44332211);
      check("commit_wv", weight_v_o, 1'b1);
      idle(1'b0);
      check("wv_one_cycle", weight_v_o, 1'b0);

      wb(8'h11, 1'b0); wb(8'h22, 1'b0); ab(8'h77, 1'b0); ab(8'h88, 1'b0);
      check("switch_act", act_o, 16'h8877);
      check("switch_av", act_v_o, 1'b1);
      check("switch_weight_held", weight_o, 32'h44332211);
      wb(8'h01, 1'b0); wb(8'h02, 1'b0); wb(8'h03, 1'b0); wb(8'h04, 1'b0);
      check("refill_weight", weight_o, 32'h04030201);
      idle(1'b1);
      check("drain_av", act_v_o, 1'b0);

      ab(8'h01, 1'b0); ab(8'h02, 1'b0); ab(8'h03, 1'b0); ab(8'h04, 1'b0);
      check("ovf_act_held", act_o, 16'h0201);
      check("ovf_set", ovf_o, 1'b1);
      step(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
      check("rstaddr_ovf", ovf_o, 1'b0);
      check("rstaddr_av", act_v_o, 1'b1);

      ab(8'hA0, 1'b0); ab(8'hA1, 1'b1);
      check("nobubble_a_av", act_v_o, 1'b1);
      check("nobubble_a_act", act_o, 16'hA1A0);
      ab(8'hB0, 1'b0); ab(8'hB1, 1'b1);
      check("nobubble_b_av", act_v_o, 1'b1);
      check("nobubble_b_act", act_o, 16'hB1B0);
      check("nobubble_ovf", ovf_o, 1'b0);
      idle(1'b1);

      wb(8'h05, 1'b0); wb(8'h06, 1'b0); wb(8'h07, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom), 1'b0, 1'b0);
      check("stall_weight_held", weight_o, 32'h04030201);
      wb(8'h08, 1'b0);
      check("stall_commit", weight_o, 32'h08070605);
      check("stall_commit_wv", weight_v_o, 1'b1);

      wb(8'h09, 1'b0); wb(8'h0A, 1'b0);
      async_reset();
      wb(8'h21, 1'b0); wb(8'h22, 1'b0); wb(8'h23, 1'b0); wb(8'h24, 1'b0);
      check("fresh_matrix", weight_o, 32'h24232221);

      wb(8'h11, 1'b0); wb(8'h22, 1'b0); wb(8'h33, 1'b0); wb(8'h44, 1'b0);
      ab(8'h77, 1'b0); ab(8'h88, 1'b0); idle(1'b0);
      ureg_chk(4'h0, 8'h11);
      ureg_chk(4'h3, 8'h44);
      ureg_chk(4'h4, 8'h77);
      ureg_chk(4'h5, 8'h88);
      ureg_chk(4'hE, 8'h40);
      ureg_chk(4'hF, 8'hA5);
      ureg_chk(4'h9, 8'h00);

      for (int i = 0; i < 400; i++) begin
         if (i == 200) async_reset();
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0),
              8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
